// File: rtl/sr_arb_pkg.sv
// Shared types and constants for the two-requester PIPO load arbiter.
// The arbitration helper covers both round-robin and fixed-priority modes.
package sr_arb_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_HOLD  = 2;
  localparam int CNT_W     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } arb_state_e;

  // Winner index for one IDLE evaluation; a tie goes to the non-owner
  // unless fixed priority is selected.
  function automatic logic pick_winner(
    input logic r0,
    input logic r1,
    input logic last,
    input logic fixed
  );
    if (r0 && r1)
      return fixed ? 1'b0 : ~last;
    return r1;
  endfunction

endpackage

// File: rtl/sr_pipo_reg.sv
// Shared WIDTH-bit parallel-in/parallel-out register.
// Async active-low clear, synchronous load enable.
module sr_pipo_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      q <= '0;
    else if (en)
      q <= d;
  end

endmodule

// File: rtl/sr_pipo_arbiter_4bit.sv
// Two-requester arbiter/load sequencer for a shared PIPO register.
// Define SR_ARB_PRIORITY_EN for fixed priority (req0 wins ties).
module sr_pipo_arbiter_4bit
  import sr_arb_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int HOLD_CYCLES = DEF_HOLD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] din0,
  input  logic [WIDTH-1:0] din1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             ack0,
  output logic             ack1,
  output logic [WIDTH-1:0] dout,
  output logic             owner,
  output logic             busy
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_LOAD = LOAD;
  localparam logic [1:0] S_HOLD = HOLD;

`ifdef SR_ARB_PRIORITY_EN
  localparam logic FIXED = 1'b1;
`else
  localparam logic FIXED = 1'b0;
`endif

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(HOLD_CYCLES - 1);

  logic [1:0]       state;
  logic [1:0]       nxt;
  logic             cur;
  logic             nxt_cur;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] nxt_cnt;
  logic             load_en;
  logic             req_cur;
  logic [WIDTH-1:0] load_data;

  assign req_cur   = cur ? req1 : req0;
  assign load_data = cur ? din1 : din0;

  always_comb begin
    nxt     = state;
    nxt_cur = cur;
    nxt_cnt = cnt;
    load_en = 1'b0;
    case (state)
      S_IDLE: begin
        if (req0 || req1) begin
          nxt     = S_LOAD;
          nxt_cur = pick_winner(req0, req1, owner, FIXED);
        end
      end
      S_LOAD: begin
        if (req_cur) begin
          load_en = 1'b1;
          nxt     = S_HOLD;
          nxt_cnt = CNT_INIT;
        end else begin
          nxt = S_IDLE;
        end
      end
      S_HOLD: begin
        // Owner dropping its request ends the hold early.
        if (!req_cur || cnt == '0)
          nxt = S_IDLE;
        else
          nxt_cnt = cnt - 1'b1;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cur   <= 1'b0;
      cnt   <= '0;
      ack0  <= 1'b0;
      ack1  <= 1'b0;
      owner <= 1'b1;
    end else begin
      state <= nxt;
      cur   <= nxt_cur;
      cnt   <= nxt_cnt;
      ack0  <= load_en & ~cur;
      ack1  <= load_en & cur;
      if (load_en)
        owner <= cur;
    end
  end

  assign busy = (state != S_IDLE);
  assign gnt0 = busy & ~cur;
  assign gnt1 = busy & cur;

  sr_pipo_reg #(
    .WIDTH(WIDTH)
  ) u_reg (
    .clk(clk),
    .rst(rst),
    .en (load_en),
    .d  (load_data),
    .q  (dout)
  );

endmodule

// File: tb/tb_sr_pipo_arbiter_4bit.sv
// Randomised bench for sr_pipo_arbiter_4bit with an ownership-level model.
// Honors SR_ARB_PRIORITY_EN the same way as the design.
module tb_sr_pipo_arbiter_4bit;

  localparam int W = 4;
  localparam int H = 2;

`ifdef SR_ARB_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         req0, req1;
  logic [W-1:0] din0, din1;
  logic         gnt0, gnt1, ack0, ack1, owner, busy;
  logic [W-1:0] dout;

  int vectors = 0;
  int miscompares = 0;
  bit run_cmp = 1'b0;

  // Model: an ownership is active for 1 load cycle plus up to H hold cycles
  bit           m_act   = 1'b0;
  bit           m_who   = 1'b0;
  int           m_age   = 0;
  bit           m_owner = 1'b1;
  logic [W-1:0] m_dout  = '0;
  bit           m_ack0  = 1'b0;
  bit           m_ack1  = 1'b0;
  bit           m_req;

  sr_pipo_arbiter_4bit #(
    .WIDTH(W),
    .HOLD_CYCLES(H)
  ) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .din0(din0), .din1(din1),
    .gnt0(gnt0), .gnt1(gnt1),
    .ack0(ack0), .ack1(ack1),
    .dout(dout), .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_act = 0; m_who = 0; m_age = 0; m_owner = 1;
      m_dout = '0; m_ack0 = 0; m_ack1 = 0;
    end else begin
      m_req  = m_who ? req1 : req0;
      m_ack0 = 0;
      m_ack1 = 0;
      if (!m_act) begin
        if (req0 || req1) begin
          if (req0 && req1) m_who = PRIO ? 1'b0 : !m_owner;
          else m_who = req1;
          m_act = 1;
          m_age = 0;
        end
      end else if (m_age == 0) begin
        if (m_req) begin
          m_dout  = m_who ? din1 : din0;
          m_owner = m_who;
          if (m_who) m_ack1 = 1; else m_ack0 = 1;
          m_age = 1;
        end else begin
          m_act = 0;
        end
      end else if (!m_req || m_age == H) begin
        m_act = 0;
      end else begin
        m_age = m_age + 1;
      end
    end
  end

  logic [9:0] exp_v, act_v;
  always @(negedge clk) begin
    if (run_cmp) begin
      exp_v = {m_act && !m_who, m_act && m_who, m_ack0, m_ack1,
               m_owner, m_act, m_dout};
      act_v = {gnt0, gnt1, ack0, ack1, owner, busy, dout};
      vectors++;
      if (act_v !== exp_v) begin
        miscompares++;
        $display("FAIL model t=%0t {g0,g1,a0,a1,own,busy,dout} got=%b want=%b",
                 $time, act_v, exp_v);
      end
    end
  end

  task automatic chk(input string n, input logic [7:0] a, input logic [7:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s t=%0t got=%0h want=%0h", n, $time, a, e);
    end
  endtask

  task automatic wait_ack(input string n, input bit who, input logic [3:0] val);
    bit seen;
    seen = 0;
    for (int k = 0; k < 12 && !seen; k++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        seen = 1;
        chk({n, "_who"}, {7'd0, ack1}, {7'd0, who});
        chk({n, "_dout"}, {4'd0, dout}, {4'd0, val});
      end
    end
    if (!seen) chk({n, "_timeout"}, 8'd0, 8'd1);
  endtask

  localparam logic [3:0] LAST_DOUT  = PRIO ? 4'b0011 : 4'b1101;
  localparam logic       LAST_OWNER = PRIO ? 1'b0 : 1'b1;

  initial begin
    rst = 0; req0 = 1; req1 = 0; din0 = 4'b0101; din1 = '0;
    @(negedge clk); run_cmp = 1;
    @(negedge clk);
    chk("rst_gnt", {6'd0, gnt0, gnt1}, 8'd0);
    chk("rst_ack", {6'd0, ack0, ack1}, 8'd0);
    chk("rst_dout", {4'd0, dout}, 8'd0);
    chk("rst_owner", {7'd0, owner}, 8'd1);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    rst = 1;
    @(negedge clk); chk("single_gnt0", {7'd0, gnt0}, 8'd1);
    @(negedge clk);
    chk("single_dout", {4'd0, dout}, 8'h5);
    chk("single_ack0", {7'd0, ack0}, 8'd1);
    @(negedge clk);
    chk("single_ack_width", {7'd0, ack0}, 8'd0);
    chk("single_hold", {7'd0, gnt0}, 8'd1);
    req0 = 0;
    @(negedge clk);
    chk("single_idle", {6'd0, gnt0, busy}, 8'd0);

    // tie right after reset: requester 0 first
    #2 rst = 0;
    @(negedge clk);
    din0 = 4'b0011; din1 = 4'b1101; req0 = 1; req1 = 1; rst = 1;
    wait_ack("tie_first", 1'b0, 4'b0011);
    wait_ack("tie_second", PRIO ? 1'b0 : 1'b1, LAST_DOUT);
    req0 = 0; req1 = 0;
    repeat (3) @(negedge clk);

    // abort in LOAD
    req1 = 1; din1 = 4'b0111;
    @(negedge clk); chk("abort_gnt1", {7'd0, gnt1}, 8'd1);
    req1 = 0;
    @(negedge clk);
    chk("abort_idle", {5'd0, gnt1, ack1, busy}, 8'd0);
    chk("abort_dout", {4'd0, dout}, {4'd0, LAST_DOUT});
    chk("abort_owner", {7'd0, owner}, {7'd0, LAST_OWNER});

    // early release with req1 pending
    req0 = 1; din0 = 4'b0101;
    @(negedge clk); chk("early_gnt0", {7'd0, gnt0}, 8'd1);
    req1 = 1; din1 = 4'b1101;
    @(negedge clk); chk("early_ack0", {7'd0, ack0}, 8'd1);
    req0 = 0;
    @(negedge clk); chk("early_idle", {6'd0, gnt0, busy}, 8'd0);
    @(negedge clk); chk("early_gnt1", {7'd0, gnt1}, 8'd1);
    @(negedge clk);
    chk("early_ack1", {7'd0, ack1}, 8'd1);
    chk("early_dout", {4'd0, dout}, 8'hd);

    // reset during HOLD
    #2 rst = 0;
    #1;
    chk("midrst_dout", {4'd0, dout}, 8'd0);
    chk("midrst_gnt", {5'd0, gnt0, gnt1, busy}, 8'd0);
    chk("midrst_owner", {7'd0, owner}, 8'd1);
    @(negedge clk);
    req0 = 1; req1 = 1; din0 = 4'b0011; rst = 1;
    @(negedge clk); chk("restart_gnt", {6'd0, gnt0, gnt1}, 8'b10);
    wait_ack("restart", 1'b0, 4'b0011);
    req0 = 0; req1 = 0;

    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (i % 97 == 50) begin
        #2 rst = 0;
        @(negedge clk);
        rst = 1;
      end
      if ($urandom_range(0, 3) == 0) req0 = ~req0;
      if ($urandom_range(0, 3) == 0) req1 = ~req1;
      if ($urandom_range(0, 2) == 0) din0 = W'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) din1 = W'($urandom_range(0, 15));
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sr_pipo_arbiter_4bit.md
# sr_pipo_arbiter_4bit

Two-requester arbiter and load sequencer for a shared 4-bit parallel-in/parallel-out register. Requesters raise a request with their data; the block grants ownership round-robin, loads the winner's word into the register, holds the value for a programmable number of cycles, then releases. It sits between producer logic and the shared PIPO register, so the register never sees two writers in one cycle.

## Interface
- WIDTH, 4, register/data width
- HOLD_CYCLES, 2, cycles the owner keeps the grant after load; legal range 1..15

- clk  input  1  sole clock, rising edge
- rst  input  1  asynchronous, active-low reset
- req0 / req1  input  1  request from requester 0 / 1; level, held until ack or abandoned
- din0 / din1  input  WIDTH  requester data; must be stable while the matching gnt is high
- gnt0 / gnt1  output  1  grant; one-hot or zero, never both
- ack0 / ack1  output  1  one-cycle pulse: register now holds that requester's word
- dout  output  WIDTH  shared register contents
- owner  output  1  index of last successful loader
- busy  output  1  high in LOAD and HOLD

## Operation
- Reset (rst low, async): state IDLE, gnt0=gnt1=0, ack0=ack1=0, dout=0, owner=1, busy=0, hold counter=0.
- States: IDLE, LOAD, HOLD.
- IDLE: sample req0/req1. None -> stay. One -> grant it. Both -> grant the requester not equal to owner, so requester 0 wins first after reset. Next state LOAD, gnt_x=1 registered.
- LOAD: if req_x still high, register captures din_x at end of cycle; next state HOLD, ack_x=1 and owner=x in first HOLD cycle; counter loaded with HOLD_CYCLES-1. If req_x low: no load, no ack, owner unchanged, gnt cleared, back to IDLE.
- HOLD: gnt_x stays high; counter decrements each cycle; at 0 -> IDLE with gnt cleared. If req_x drops in HOLD, release early: IDLE next cycle.
- Requests arriving during LOAD/HOLD wait; they are evaluated in the next IDLE cycle. The block spends at least one IDLE cycle between ownerships.
- dout changes only on successful LOAD; it keeps its value through IDLE and across grants.

## Timing
- req_x high in IDLE cycle N -> gnt_x high in N+1 (LOAD) -> dout=din_x and ack_x pulse in N+2 -> gnt_x high through N+1+HOLD_CYCLES -> IDLE in N+2+HOLD_CYCLES.
- Request-to-data latency: 2 cycles. Back-to-back ownership period: HOLD_CYCLES+2 cycles.
- ack_x is exactly one cycle wide; never asserted without a completed load.
- rst asserted mid-LOAD/HOLD: all outputs take reset values immediately; the partial load is discarded.
- rst deassertion is synchronised by the system; first IDLE evaluation happens on the first rising edge after release.

## Configuration
- SR_ARB_PRIORITY_EN defined: fixed priority, req0 always wins a tie; owner is still reported but not used for arbitration.
- Undefined (default): round-robin as described in Operation.

## Structure
- Package sr_arb_pkg: state enum typedef (IDLE, LOAD, HOLD), default WIDTH and HOLD_CYCLES constants, counter width derived as 4 bits.
- Sub-module sr_pipo_reg: WIDTH-bit register with async active-low reset and load enable; the arbiter drives its enable and data mux.

## Test plan
- Reset: rst low with req0=1, din0=4'b0101 -> gnt=0, ack=0, dout=0, owner=1, busy=0 throughout.
- Single request: req0=1, din0=4'b0101 in IDLE -> gnt0 next cycle, dout=4'b0101 and ack0 pulse two cycles later, gnt0 high for 2 cycles after load, then IDLE.
- Tie: req0=req1=1, din0=4'b0011, din1=4'b1101 -> requester 0 loaded first (dout=4'b0011), then requester 1 (dout=4'b1101), no cycle with both gnts high; with SR_ARB_PRIORITY_EN and req0 held, requester 0 reloads every period and req1 is starved.
- Abort: req1=1, din1=4'b0111, drop req1 in the LOAD cycle -> no ack1, dout unchanged, owner unchanged, IDLE next cycle.
- Early release: req0 dropped in first HOLD cycle -> gnt0 low and IDLE the next cycle; pending req1 granted the cycle after.
- Reset mid-HOLD: assert rst during HOLD after loading 4'b1101 -> dout=0, gnt=0, busy=0 immediately; after release, arbitration restarts with requester 0 preferred.
